// File: rtl/pipe_reg.sv
// Pipeline stage register with stall (en=0) and flush/reset bubble insertion.
// Optional occupancy flag output `valid` is built when PIPE_REG_VALID_EN is defined.
module pipe_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    input  logic [W-1:0] bubble,
`ifdef PIPE_REG_VALID_EN
    output logic         valid,
`endif
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    // Reset and flush share the bubble path, so one select covers both.
    logic load_bubble;
    assign load_bubble = rst | flush;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            always_comb begin
                q_next[gi] = q_reg[gi];
                if (load_bubble) begin
                    q_next[gi] = bubble[gi];
                end else if (en) begin
                    q_next[gi] = d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        q_reg <= q_next;
    end

    assign q = q_reg;

`ifdef PIPE_REG_VALID_EN
    logic valid_reg;
    logic valid_next;

    always_comb begin
        valid_next = valid_reg;
        if (load_bubble) begin
            valid_next = 1'b0;
        end else if (en) begin
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    assign valid = valid_reg;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Directed self-checking bench for pipe_reg: reset, streaming loads, stalls,
// flush (with and without enable), reset priority and bubble sampling.
module tb_pipe_reg;

    localparam int W = 32;
    localparam logic [W-1:0] NOP = 32'h00000013;

    logic         clk;
    logic         rst;
    logic         en;
    logic         flush;
    logic [W-1:0] d;
    logic [W-1:0] bubble;
    logic [W-1:0] q;
`ifdef PIPE_REG_VALID_EN
    logic         valid;
`endif

    int tests_run;
    int tests_failed;

    pipe_reg #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .flush  (flush),
        .d      (d),
        .bubble (bubble),
`ifdef PIPE_REG_VALID_EN
        .valid  (valid),
`endif
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one posedge, then settle on the following negedge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; d = '0; bubble = NOP;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (q !== NOP) begin
                tests_failed++;
                $display("FAIL reset_q cycle %0d: got %h expected %h", i, q, NOP);
            end
`ifdef PIPE_REG_VALID_EN
            tests_run++;
            if (valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_valid cycle %0d: got %b expected 0", i, valid);
            end
`endif
        end
        $display("[TB] reset: q=%h", q);
    endtask

    task automatic test_load_stream();
        logic [W-1:0] vals [3];
        vals[0] = 32'h11112222;
        vals[1] = 32'h71512922;
        vals[2] = 32'h11452222;
        rst = 1'b0; en = 1'b1; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = vals[i];
            step();
            tests_run++;
            if (q !== vals[i]) begin
                tests_failed++;
                $display("FAIL load_stream[%0d]: got %h expected %h", i, q, vals[i]);
            end
`ifdef PIPE_REG_VALID_EN
            tests_run++;
            if (valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL load_valid[%0d]: got %b expected 1", i, valid);
            end
`endif
            $display("[TB] load: d=%h q=%h", vals[i], q);
        end
    endtask

    task automatic test_stall();
        en = 1'b0; d = 32'hAAAABBBB;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (q !== 32'h11452222) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got %h expected 11452222", i, q);
            end
`ifdef PIPE_REG_VALID_EN
            tests_run++;
            if (valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_valid[%0d]: got %b expected 1", i, valid);
            end
`endif
            $display("[TB] stall: q=%h", q);
        end
        en = 1'b1;
        step();
        tests_run++;
        if (q !== 32'hAAAABBBB) begin
            tests_failed++;
            $display("FAIL stall_release: got %h expected aaaabbbb", q);
        end
        $display("[TB] release: q=%h", q);
    endtask

    task automatic test_flush_en();
        flush = 1'b1; en = 1'b1; d = 32'hCCCCDDDD;
        step();
        tests_run++;
        if (q !== NOP) begin
            tests_failed++;
            $display("FAIL flush_en: got %h expected %h", q, NOP);
        end
`ifdef PIPE_REG_VALID_EN
        tests_run++;
        if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_en_valid: got %b expected 0", valid);
        end
`endif
        flush = 1'b0;
        $display("[TB] flush+en: q=%h", q);
    endtask

    task automatic test_flush_stall();
        en = 1'b1; flush = 1'b0; d = 32'h11112222;
        step();
        tests_run++;
        if (q !== 32'h11112222) begin
            tests_failed++;
            $display("FAIL flush_stall_load: got %h expected 11112222", q);
        end
        flush = 1'b1; en = 1'b0; d = 32'hCCCCDDDD;
        step();
        tests_run++;
        if (q !== NOP) begin
            tests_failed++;
            $display("FAIL flush_stall: got %h expected %h", q, NOP);
        end
        flush = 1'b0;
        $display("[TB] flush+stall: q=%h", q);
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; flush = 1'b0; en = 1'b1; d = 32'hDEADBEEF; bubble = NOP;
        step();
        tests_run++;
        if (q !== NOP) begin
            tests_failed++;
            $display("FAIL reset_priority: got %h expected %h", q, NOP);
        end
        rst = 1'b0;
        step();
        tests_run++;
        if (q !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL reset_release: got %h expected deadbeef", q);
        end
        $display("[TB] reset priority: q=%h", q);
    endtask

    // Bubble is sampled at the edge, not fixed at reset time.
    task automatic test_bubble_sample();
        bubble = 32'hFFFF0000; flush = 1'b1; en = 1'b0;
        step();
        tests_run++;
        if (q !== 32'hFFFF0000) begin
            tests_failed++;
            $display("FAIL bubble_sample: got %h expected ffff0000", q);
        end
        flush = 1'b0; bubble = NOP; en = 1'b0;
        step();
        tests_run++;
        if (q !== 32'hFFFF0000) begin
            tests_failed++;
            $display("FAIL bubble_hold: got %h expected ffff0000", q);
        end
        $display("[TB] bubble sample: q=%h", q);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; en = 1'b0; flush = 1'b0; d = '0; bubble = NOP;
        @(negedge clk);
        test_reset();
        test_load_stream();
        test_stall();
        test_flush_en();
        test_flush_stall();
        test_reset_priority();
        test_bubble_sample();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
